// File: rtl/even_div_ctrl_if.sv
// Configuration handshake bundle for even_div_ctrl: a half-period offered with valid/ready.
interface even_div_ctrl_if #(
  parameter int unsigned CNT_W = 8
);
  logic             cfg_valid;
  logic [CNT_W-1:0] cfg_half;
  logic             cfg_ready;

  modport master (
    output cfg_valid,
    output cfg_half,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_half,
    output cfg_ready
  );
endinterface

// File: rtl/even_div_ctrl.sv
// Runtime-programmable even clock divider: 50% duty output of period 2*active, with new
// ratios taken over only at the end of a full period so div_out never glitches.
module even_div_ctrl #(
  parameter int unsigned CNT_W = 8
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         enable,
  even_div_ctrl_if.slave cfg,
  output logic         div_out,
  output logic         tick,
  output logic         busy
);

  typedef enum logic [1:0] {StIdle, StRun, StPend} state_e;

  localparam logic [CNT_W-1:0] One = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] active_q, active_d;
  logic [CNT_W-1:0] pending_q, pending_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             div_q, div_d;
  logic             tick_q, tick_d;
  logic             xfer;
  logic             last;

  assign cfg.cfg_ready = (state_q != StPend);
  assign busy          = (state_q != StIdle);
  assign div_out       = div_q;
  assign tick          = tick_q;

  assign xfer = cfg.cfg_valid && cfg.cfg_ready;
  assign last = (cnt_q == (active_q - One));

  always_comb begin
    state_d   = state_q;
    active_d  = active_q;
    pending_d = pending_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    tick_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        div_d = 1'b0;
        if (xfer) active_d = cfg.cfg_half;
        // Start decision uses the ratio held before any same-cycle write.
        if (enable && (active_q != '0)) begin
          state_d = StRun;
          div_d   = 1'b1;
          tick_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      StRun, StPend: begin
        if (!last) begin
          cnt_d = cnt_q + One;
          if (state_q == StRun && xfer) begin
            pending_d = cfg.cfg_half;
            state_d   = StPend;
          end
        end else if (div_q) begin
          cnt_d = '0;
          div_d = 1'b0;
          if (state_q == StRun && xfer) begin
            pending_d = cfg.cfg_half;
            state_d   = StPend;
          end
        end else begin
          // Period boundary: end of the low phase.
          cnt_d = '0;
          if (state_q == StPend) begin
            active_d = pending_q;
            if ((pending_q == '0) || !enable) begin
              state_d = StIdle;
            end else begin
              state_d = StRun;
              div_d   = 1'b1;
              tick_d  = 1'b1;
            end
          end else if (!enable) begin
            state_d = StIdle;
            // A config arriving as we stop is kept rather than dropped.
            if (xfer) active_d = cfg.cfg_half;
          end else begin
            div_d  = 1'b1;
            tick_d = 1'b1;
            if (xfer) begin
              pending_d = cfg.cfg_half;
              state_d   = StPend;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StIdle;
      active_q  <= '0;
      pending_q <= '0;
      cnt_q     <= '0;
      div_q     <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      tick_q    <= tick_d;
    end
  end

endmodule
